// File: rtl/data_mem_wait.sv
// Word-organised data memory for the core load/store path, byte-lane stores, programmable wait states.
// Latency: request accepted in cycle T completes with a one-cycle ready_o pulse in cycle T+LATENCY.
// Backpressure: stall_o holds the core while a request is pending; requests are only sampled in IDLE.
module data_mem_wait #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        write_enable_i,
  input  logic [3:0]  byte_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          ready_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          acc_we;
  logic [3:0]    acc_be;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [31:0]   acc_off;
  logic [IW-1:0] acc_idx;
  logic [1:0]    low_lane;
  logic          be_legal;
  logic          range_err;
  logic          align_err;
  logic          acc_err;
  logic          enter_resp;

  // In IDLE the live inputs describe the access (needed when LATENCY==1), otherwise the latched copy does
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we    = write_enable_i;
      acc_be    = byte_enable_i;
      acc_addr  = addr_i;
      acc_wdata = write_data_i;
    end else begin
      acc_we    = we_q;
      acc_be    = be_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  // Legal lane patterns and the lane the address must point at
  always_comb begin
    be_legal = 1'b1;
    low_lane = 2'd0;
    case (acc_be)
      4'b0001, 4'b0011, 4'b1111: low_lane = 2'd0;
      4'b0010:                   low_lane = 2'd1;
      4'b0100, 4'b1100:          low_lane = 2'd2;
      4'b1000:                   low_lane = 2'd3;
      default:                   be_legal = 1'b0;
    endcase
  end

  assign acc_off    = acc_addr - BASE_ADDR;
  assign acc_idx    = acc_off[IW+1:2];
  assign range_err  = (acc_addr < BASE_ADDR) || ((acc_off >> 2) >= 32'(DEPTH_WORDS));
  assign align_err  = (acc_addr[1:0] != low_lane);
  assign acc_err    = range_err || !be_legal || align_err;

  // The edge that moves the FSM into RESP performs the array access
  assign enter_resp = ((state_q == S_IDLE) && mem_req_i && (LATENCY == 1)) ||
                      ((state_q == S_WAIT) && (cnt_q == CW'(1)));

  // Control FSM with registered completion outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      ready_q <= enter_resp;
      if (enter_resp) begin
        err_q <= acc_err;
        if (acc_err)      rdata_q <= '0;
        else if (!acc_we) rdata_q <= mem_q[acc_idx];
      end
      case (state_q)
        S_IDLE: begin
          if (mem_req_i) begin
            we_q    <= write_enable_i;
            be_q    <= byte_enable_i;
            addr_q  <= addr_i;
            wdata_q <= write_data_i;
            if (LATENCY == 1) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CW'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Single write port; a reset on the completing edge suppresses the store
  always_ff @(posedge clk_i) begin
    if (!rst_i && enter_resp && acc_we && !acc_err) begin
      for (int n = 0; n < 4; n++) begin
        if (acc_be[n]) mem_q[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
      end
    end
  end

  assign read_data_o = rdata_q;
  assign ready_o     = ready_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != S_IDLE);
  assign stall_o     = mem_req_i && !ready_q;

endmodule

// File: tb/tb_data_mem_wait.sv
// Self-checking bench for data_mem_wait: random and directed accesses against a word-array reference model.
// Expected completions are queued at issue time and checked by an independent monitor on ready_o.
// Timing of ready_o, busy_o and stall_o is checked against the cycle an access was presented in IDLE.
module tb_data_mem_wait;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        mem_req_i;
  logic        write_enable_i;
  logic [3:0]  byte_enable_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        ready_o;
  logic        busy_o;
  logic        stall_o;
  logic        err_o;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    bit          chk_rd;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem_m [DEPTH];
  int          cyc = 0;
  int          nvec = 0;
  int          nfail = 0;

  data_mem_wait #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .mem_req_i     (mem_req_i),
    .write_enable_i(write_enable_i),
    .byte_enable_i (byte_enable_i),
    .addr_i        (addr_i),
    .write_data_i  (write_data_i),
    .read_data_o   (read_data_o),
    .ready_o       (ready_o),
    .busy_o        (busy_o),
    .stall_o       (stall_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Access rules stated directly: in range, legal lane pattern, address points at lowest enabled lane
  function automatic bit model_err(input logic [31:0] a, input logic [3:0] be);
    bit e = 0;
    int low = 0;
    if (a < BASE) e = 1;
    else if (((a - BASE) / 4) >= DEPTH) e = 1;
    if (!(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})) e = 1;
    for (int n = 3; n >= 0; n--) if (be[n]) low = n;
    if (int'(a[1:0]) != low) e = 1;
    return e;
  endfunction

  // Apply the access to the model and queue its completion due LAT cycles from now
  task automatic model_push(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   w;
    e.err    = model_err(a, be);
    e.rd     = 32'h0;
    e.chk_rd = 1'b1;
    e.due    = cyc + LAT;
    if (!e.err) begin
      w = int'((a - BASE) / 4);
      if (we) begin
        for (int n = 0; n < 4; n++) if (be[n]) mem_m[w][8*n +: 8] = wd[8*n +: 8];
        e.chk_rd = 1'b0;
      end else begin
        e.rd = mem_m[w];
      end
    end
    sbq.push_back(e);
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 into the next idle cycle
  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
    mem_req_i      = 1'b1;
    write_enable_i = we;
    byte_enable_i  = be;
    addr_i         = a;
    write_data_i   = wd;
    model_push(we, be, a, wd);
    repeat (LAT) begin @(posedge clk); #1; end
    if (!hold) mem_req_i = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: every completion must match the head of the scoreboard, on time
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i) begin
      if (ready_o) begin
        if (sbq.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL unexpected_ready at cycle %0d: got ready_o=1 expected no completion", cyc);
        end else begin
          e = sbq.pop_front();
          check("ready_cycle", 32'(cyc), 32'(e.due));
          check("err_o", {31'h0, err_o}, {31'h0, e.err});
          if (e.chk_rd) check("read_data_o", read_data_o, e.rd);
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
        e = sbq.pop_front();
        nvec++;
        nfail++;
        $display("FAIL missing_ready at cycle %0d: got no ready_o expected one at cycle %0d", cyc, e.due);
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  be;
    logic [3:0]  legal_be [7];
    int          w;
    int          low;
    legal_be = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    rst_i = 1'b1; mem_req_i = 1'b0; write_enable_i = 1'b0;
    byte_enable_i = 4'h0; addr_i = 32'h0; write_data_i = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset_ready_o", {31'h0, ready_o}, 32'h0);
    check("reset_busy_o", {31'h0, busy_o}, 32'h0);
    check("reset_err_o", {31'h0, err_o}, 32'h0);
    check("reset_read_data_o", read_data_o, 32'h0);
    check("reset_stall_o", {31'h0, stall_o}, 32'h0);
    @(posedge clk); #1;

    // Give every word a known value
    for (int i = 0; i < int'(DEPTH); i++)
      issue(1'b1, 4'hF, BASE + 32'(4 * i), $urandom, 1'b0);

    // Full-word store then load
    issue(1'b1, 4'b1111, BASE + 32'h10, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 4'b1111, BASE + 32'h10, 32'h0, 1'b0);

    // Byte store into a cleared word
    issue(1'b1, 4'b1111, BASE + 32'h10, 32'h0, 1'b0);
    issue(1'b1, 4'b0010, BASE + 32'h11, 32'h0000AB00, 1'b0);
    issue(1'b0, 4'b1111, BASE + 32'h10, 32'h0, 1'b0);
    check("byte_store_model", mem_m[4], 32'h0000AB00);

    // busy_o / stall_o profile across one load
    mem_req_i = 1'b1; write_enable_i = 1'b0; byte_enable_i = 4'hF;
    addr_i = BASE + 32'h10; write_data_i = 32'h0;
    model_push(1'b0, 4'hF, BASE + 32'h10, 32'h0);
    for (int i = 0; i <= int'(LAT); i++) begin
      @(negedge clk);
      check("busy_o", {31'h0, busy_o}, {31'h0, (i > 0)});
      check("stall_o", {31'h0, stall_o}, {31'h0, (i < int'(LAT))});
      if (i == int'(LAT)) mem_req_i = 1'b0;
      @(posedge clk); #1;
    end

    // Rejected accesses, then confirm the targeted words are untouched
    issue(1'b1, 4'b1111, BASE + 32'(4 * DEPTH), 32'hFFFFFFFF, 1'b0);
    issue(1'b1, 4'b0110, BASE + 32'h20, 32'hFFFFFFFF, 1'b0);
    issue(1'b1, 4'b1111, BASE + 32'h22, 32'hFFFFFFFF, 1'b0);
    issue(1'b0, 4'b1111, BASE - 32'h4, 32'h0, 1'b0);
    issue(1'b0, 4'b1111, BASE + 32'h20, 32'h0, 1'b0);

    // Reset while a store waits: no completion, no write
    mem_req_i = 1'b1; write_enable_i = 1'b1; byte_enable_i = 4'hF;
    addr_i = BASE + 32'h40; write_data_i = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b1; mem_req_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("abort_busy_o", {31'h0, busy_o}, 32'h0);
    check("abort_ready_o", {31'h0, ready_o}, 32'h0);
    check("abort_read_data_o", read_data_o, 32'h0);
    issue(1'b0, 4'b1111, BASE + 32'h40, 32'h0, 1'b0);

    // Request held high through RESP: one completion per accept
    for (int i = 0; i < 6; i++)
      issue(i[0], 4'hF, BASE + 32'(4 * (i + 8)), $urandom, (i < 5));

    // Random traffic, mostly legal, some misaligned / out of range / bad lanes
    for (int i = 0; i < 160; i++) begin
      w = int'($urandom_range(0, DEPTH + 3)) - 2;
      be = legal_be[$urandom_range(0, 6)];
      if ($urandom_range(0, 9) == 0) be = 4'($urandom);
      low = 0;
      for (int n = 3; n >= 0; n--) if (be[n]) low = n;
      a = BASE + 32'(4 * w) + 32'(low);
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom);
      issue(1'($urandom), be, a, $urandom, ($urandom_range(0, 3) == 0) && (i < 159));
    end

    repeat (LAT + 2) @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      nvec++;
      nfail++;
      $display("FAIL outstanding_completions: got %0d pending expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
